// File: rtl/code_loader.sv
`default_nettype none
// ============================================================================
// Module   : code_loader
// Purpose  : Writer side of the CPU code memory. Receives a framed byte
//            stream (sync, word count, little-endian data, XOR checksum),
//            writes each assembled 32-bit word into code memory and holds
//            the CPU in reset until a complete, checksum-valid image is in.
// Revision : 1.0 - initial release
// ============================================================================
module code_loader #(
   parameter int CODE_WORDS = 8,
   parameter int ADDR_W     = $clog2(CODE_WORDS)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_nreset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [7:0] C_SYNC  = 8'hA5;
   localparam logic [7:0] C_MAX_N = 8'(CODE_WORDS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t              state_q,     state_d;
   logic                in_ready_q,  in_ready_d;
   logic                we_q,        we_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [31:0]         wdata_q,     wdata_d;
   logic                cpu_nrst_q,  cpu_nrst_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                error_q,     error_d;
   logic [ADDR_W-1:0]   last_q,      last_d;   // index of the final word (N-1)
   logic [ADDR_W-1:0]   widx_q,      widx_d;   // word currently being assembled
   logic [1:0]          bidx_q,      bidx_d;   // byte lane within that word
   logic [7:0]          xor_q,       xor_d;    // running checksum of data bytes
   logic [23:0]         asm_q,       asm_d;    // lower three lanes; lane 3 comes straight from in_data

   logic                w_accept;

   assign w_accept = in_valid && in_ready_q;

   // State register and all registered outputs; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cpu_nrst_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         last_q     <= '0;
         widx_q     <= '0;
         bidx_q     <= '0;
         xor_q      <= '0;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cpu_nrst_q <= cpu_nrst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         last_q     <= last_d;
         widx_q     <= widx_d;
         bidx_q     <= bidx_d;
         xor_q      <= xor_d;
         asm_q      <= asm_d;
      end
   end

   // Frame parser: next state, word assembly, checksum and output updates
   always_comb begin
      state_d    = state_q;
      in_ready_d = 1'b1;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cpu_nrst_d = cpu_nrst_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      last_d     = last_q;
      widx_d     = widx_q;
      bidx_d     = bidx_q;
      xor_d      = xor_q;
      asm_d      = asm_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            // Anything other than the sync byte is silently dropped
            if (w_accept && (in_data == C_SYNC)) begin
               state_d    = S_LEN;
               cpu_nrst_d = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
            end
         end

         S_LEN: begin
            if (w_accept) begin
               if ((in_data == 8'd0) || (in_data > C_MAX_N)) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_DATA;
                  last_d  = ADDR_W'(in_data - 8'd1);
                  widx_d  = '0;
                  bidx_d  = '0;
                  xor_d   = '0;
               end
            end
         end

         S_DATA: begin
            // Sync-valued bytes are plain data here
            if (w_accept) begin
               xor_d  = xor_q ^ in_data;
               bidx_d = bidx_q + 2'd1;
               case (bidx_q)
                  2'd0:    asm_d[7:0]   = in_data;
                  2'd1:    asm_d[15:8]  = in_data;
                  2'd2:    asm_d[23:16] = in_data;
                  default: begin
                     we_d    = 1'b1;
                     addr_d  = widx_q;
                     wdata_d = {in_data, asm_q};
                     widx_d  = widx_q + 1'b1;
                     if (widx_q == last_q) begin
                        state_d = S_CSUM;
                     end
                  end
               endcase
            end
         end

         S_CSUM: begin
            if (w_accept) begin
               busy_d = 1'b0;
               if (in_data == xor_q) begin
                  state_d    = S_DONE;
                  cpu_nrst_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_nreset = cpu_nrst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_code_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_loader
// Purpose  : Self-checking bench for code_loader. Frames are built from word
//            lists; expected writes, write timing and final status follow
//            from the frame contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_loader;

   localparam int CODE_WORDS = 8;
   localparam int ADDR_W     = 3;

   logic              clk = 1'b0;
   logic              nreset = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_nreset;
   logic              busy;
   logic              done;
   logic              error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  tx_q[$];     // bytes to send
   int          acc_cyc[$];  // cycle stamp at which each byte was presented
   logic [31:0] exp_w[$];    // words carried by the current frame
   logic [2:0]  wa_q[$];     // observed write addresses
   logic [31:0] wd_q[$];     // observed write data
   int          wc_q[$];     // observed write cycles

   code_loader #(.CODE_WORDS(CODE_WORDS), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_nreset(cpu_nreset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
         wc_q.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
   endtask

   // Append a frame for exp_w to tx_q; checksum optionally corrupted
   task automatic make_frame(input bit corrupt);
      logic [7:0] x;
      logic [31:0] w;
      x = 8'h00;
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'(exp_w.size()));
      foreach (exp_w[k]) begin
         w = exp_w[k];
         for (int b = 0; b < 4; b++) begin
            tx_q.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
         end
      end
      tx_q.push_back(corrupt ? (x ^ 8'h5A) : x);
   endtask

   // Present tx_q with random idle gaps; returns just after the last byte is taken
   task automatic drive(input int gap_pct);
      acc_cyc.delete();
      for (int i = 0; i < tx_q.size(); i++) begin
         while ($urandom_range(99) < gap_pct) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = tx_q[i];
         acc_cyc.push_back(cyc);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      nreset   = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b0 || mem_we !== 1'b0 || cpu_nreset !== 1'b0 ||
             busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
             mem_addr !== 3'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: rdy=%b we=%b cpu_nrst=%b busy=%b done=%b err=%b addr=%0d data=%h, required all zero",
                     i, in_ready, mem_we, cpu_nreset, busy, done, error, mem_addr, mem_wdata);
         end
      end
      in_valid = 1'b0;
      nreset   = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_good_load();
      tx_q = '{8'hA5, 8'h02, 8'h01, 8'h20, 8'h82, 8'hE0, 8'hFD, 8'hFF, 8'hFF, 8'hEA, 8'h54};
      clear_obs();
      drive(0);
      total++;
      if (wd_q.size() != 2) begin
         bad++;
         $display("FAIL good_count: writes=%0d required 2", wd_q.size());
      end else begin
         total++;
         if (wa_q[0] !== 3'd0 || wd_q[0] !== 32'hE0822001 || wc_q[0] != acc_cyc[5] + 1) begin
            bad++;
            $display("FAIL good_w0: addr=%0d data=%h cyc=%0d required 0 e0822001 %0d",
                     wa_q[0], wd_q[0], wc_q[0], acc_cyc[5] + 1);
         end
         total++;
         if (wa_q[1] !== 3'd1 || wd_q[1] !== 32'hEAFFFFFD || wc_q[1] != acc_cyc[9] + 1) begin
            bad++;
            $display("FAIL good_w1: addr=%0d data=%h cyc=%0d required 1 eafffffd %0d",
                     wa_q[1], wd_q[1], wc_q[1], acc_cyc[9] + 1);
         end
      end
      total++;
      if (done !== 1'b1 || cpu_nreset !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL good_status: done=%b cpu_nrst=%b err=%b busy=%b required 1 1 0 0",
                  done, cpu_nreset, error, busy);
      end
   endtask

   task automatic test_bad_csum();
      tx_q = '{8'hA5, 8'h02, 8'h01, 8'h20, 8'h82, 8'hE0, 8'hFD, 8'hFF, 8'hFF, 8'hEA, 8'h55};
      clear_obs();
      drive(0);
      total++;
      if (wd_q.size() != 2 || wd_q[0] !== 32'hE0822001 || wd_q[1] !== 32'hEAFFFFFD) begin
         bad++;
         $display("FAIL badcs_writes: count=%0d required 2 writes e0822001,eafffffd", wd_q.size());
      end
      total++;
      if (error !== 1'b1 || cpu_nreset !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL badcs_status: err=%b cpu_nrst=%b done=%b busy=%b required 1 0 0 0",
                  error, cpu_nreset, done, busy);
      end
   endtask

   task automatic test_len_errors();
      logic [7:0] lens [2];
      lens[0] = 8'h00;
      lens[1] = 8'h09;
      for (int i = 0; i < 2; i++) begin
         tx_q = '{8'hA5, lens[i]};
         clear_obs();
         drive(0);
         repeat (2) @(negedge clk);
         #1;
         total++;
         if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cpu_nreset !== 1'b0 || wd_q.size() != 0) begin
            bad++;
            $display("FAIL len_err[%h]: err=%b done=%b busy=%b cpu_nrst=%b writes=%0d required 1 0 0 0 0",
                     lens[i], error, done, busy, cpu_nreset, wd_q.size());
         end
      end
      exp_w = '{32'h11223344, 32'hCAFEF00D, 32'h0BADBEEF};
      tx_q.delete();
      make_frame(1'b0);
      clear_obs();
      drive(0);
      total++;
      if (done !== 1'b1 || error !== 1'b0 || wd_q.size() != 3) begin
         bad++;
         $display("FAIL len_recover: done=%b err=%b writes=%0d required 1 0 3", done, error, wd_q.size());
      end
   endtask

   task automatic test_garbage_throttle();
      // Two junk bytes ahead of the spec frame, random gaps throughout
      tx_q = '{8'h3C, 8'h77, 8'hA5, 8'h02, 8'h01, 8'h20, 8'h82, 8'hE0,
               8'hFD, 8'hFF, 8'hFF, 8'hEA, 8'h54};
      exp_w = '{32'hE0822001, 32'hEAFFFFFD};
      clear_obs();
      drive(45);
      total++;
      if (wd_q.size() != 2) begin
         bad++;
         $display("FAIL throttle_count: writes=%0d required 2", wd_q.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            total++;
            if (wa_q[k] !== 3'(k) || wd_q[k] !== exp_w[k] || wc_q[k] != acc_cyc[2 + 2 + 4*k + 3] + 1) begin
               bad++;
               $display("FAIL throttle_w%0d: addr=%0d data=%h cyc=%0d required %0d %h %0d",
                        k, wa_q[k], wd_q[k], wc_q[k], k, exp_w[k], acc_cyc[2 + 2 + 4*k + 3] + 1);
            end
         end
      end
      total++;
      if (done !== 1'b1 || cpu_nreset !== 1'b1) begin
         bad++;
         $display("FAIL throttle_status: done=%b cpu_nrst=%b required 1 1", done, cpu_nreset);
      end
      // Sync-valued bytes inside the data are stored, not treated as resync
      exp_w = '{32'h12A5A534, 32'hA5000000};
      tx_q.delete();
      make_frame(1'b0);
      clear_obs();
      drive(20);
      total++;
      if (wd_q.size() != 2 || wd_q[0] !== 32'h12A5A534 || wd_q[1] !== 32'hA5000000 || done !== 1'b1) begin
         bad++;
         $display("FAIL sync_as_data: writes=%0d done=%b required 2 writes 12a5a534,a5000000 done=1",
                  wd_q.size(), done);
      end
   endtask

   task automatic test_reload_reset();
      tx_q = '{8'hA5};
      drive(0);
      total++;
      if (cpu_nreset !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL reload_sync: cpu_nrst=%b busy=%b done=%b required 0 1 0", cpu_nreset, busy, done);
      end
      tx_q = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      drive(0);
      nreset = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 3'd0 || mem_wdata !== 32'd0 ||
          cpu_nreset !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         bad++;
         $display("FAIL midframe_reset: rdy=%b we=%b addr=%0d data=%h cpu_nrst=%b busy=%b done=%b err=%b required all zero",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_nreset, busy, done, error);
      end
      nreset = 1'b1;
      exp_w = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'hFFEEDDCC};
      tx_q.delete();
      make_frame(1'b0);
      clear_obs();
      drive(10);
      total++;
      if (wd_q.size() != 4 || wd_q[0] !== exp_w[0] || wd_q[3] !== exp_w[3] || wa_q[3] !== 3'd3 ||
          done !== 1'b1 || cpu_nreset !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_load: writes=%0d done=%b cpu_nrst=%b required 4 writes done=1 cpu_nrst=1",
                  wd_q.size(), done, cpu_nreset);
      end
   endtask

   task automatic test_random_frames();
      int n;
      bit corrupt;
      for (int f = 0; f < 8; f++) begin
         n = (f == 0) ? CODE_WORDS : int'($urandom_range(CODE_WORDS, 1));
         corrupt = ($urandom_range(3) == 0);
         exp_w.delete();
         for (int k = 0; k < n; k++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(3) == 0) w[8*(k%4) +: 8] = 8'hA5;
            exp_w.push_back(w);
         end
         tx_q.delete();
         make_frame(corrupt);
         clear_obs();
         drive(30);
         total++;
         if (wd_q.size() != n) begin
            bad++;
            $display("FAIL rand%0d_count: writes=%0d required %0d", f, wd_q.size(), n);
         end else begin
            for (int k = 0; k < n; k++) begin
               total++;
               if (wa_q[k] !== 3'(k) || wd_q[k] !== exp_w[k] || wc_q[k] != acc_cyc[2 + 4*k + 3] + 1) begin
                  bad++;
                  $display("FAIL rand%0d_w%0d: addr=%0d data=%h cyc=%0d required %0d %h %0d",
                           f, k, wa_q[k], wd_q[k], wc_q[k], k, exp_w[k], acc_cyc[2 + 4*k + 3] + 1);
               end
            end
         end
         total++;
         if (done !== !corrupt || error !== corrupt || cpu_nreset !== !corrupt || busy !== 1'b0) begin
            bad++;
            $display("FAIL rand%0d_status: done=%b err=%b cpu_nrst=%b busy=%b required %b %b %b 0",
                     f, done, error, cpu_nreset, busy, !corrupt, corrupt, !corrupt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_csum();
      test_len_errors();
      test_garbage_throttle();
      test_reload_reset();
      test_random_frames();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/code_loader.md
Name: code_loader

Overview:
- Writer side of the CPU code memory. The CPU only reads code memory; this block fills it.
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes each completed word into code memory and holds the CPU in reset until a complete, checksum-valid image has been loaded.

Parameters:
- CODE_WORDS, 8, depth of code memory in 32-bit words; also the maximum frame length.
- ADDR_W, $clog2(CODE_WORDS), width of the word address into code memory.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- nreset  input  1  synchronous active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  code memory write strobe, one-cycle pulse.
- mem_addr  output  ADDR_W  code memory word address.
- mem_wdata  output  32  code memory write data.
- cpu_nreset  output  1  active-low reset to the CPU core.
- busy  output  1  frame in progress.
- done  output  1  last frame loaded OK.
- error  output  1  last frame rejected.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on nreset, sampled at posedge. All outputs are registered.
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_nreset=0, busy=0, done=0, error=0. Reset mid-frame abandons the frame; already-written words stay in memory.
- in_ready=1 in every cycle after reset is released. A byte is accepted at a posedge where in_valid && in_ready.
- Frame format, in order:
  - 0xA5 sync byte.
  - N, the word count.
  - 4N data bytes, little-endian per word: first byte is word[7:0].
  - Checksum byte: XOR of all 4N data bytes.
- States:
  - IDLE / DONE / ERR: accepted 0xA5 -> LEN. Next cycle: cpu_nreset=0, busy=1, done=0, error=0. Any other byte is consumed and ignored.
  - LEN: if N==0 or N>CODE_WORDS -> ERR. Otherwise latch N, clear word index, byte index and running XOR, then go to DATA.
  - DATA: each accepted byte is shifted into the word assembly register at lane [byte_idx], and XORed into the running checksum.
    - On the 4th byte of word k: the next cycle has mem_we=1, mem_addr=k, mem_wdata=assembled word. This is exactly one cycle of latency and a one-cycle pulse.
    - After word N-1 -> CSUM.
    - Back-to-back bytes every cycle must be sustained without loss.
  - CSUM:
    - Byte == running XOR -> DONE. Next cycle: cpu_nreset=1, done=1, busy=0.
    - Mismatch -> ERR. Next cycle: error=1, busy=0, cpu_nreset stays 0.
- cpu_nreset is released only on entry to DONE. It is reasserted (0) the cycle after any new sync byte is accepted, so re-loading always restarts the CPU from PC 0.
- A 0xA5 byte inside DATA or CSUM is ordinary data, not a resync.
- Word index wraps never: N ≤ CODE_WORDS is enforced in LEN.
- mem_addr holds its last value when mem_we=0.

Test Plan:
- Reset hold: nreset=0 for 3 cycles with in_valid=1 -> in_ready=0, mem_we=0, cpu_nreset=0 throughout. After release, in_ready=1 the next cycle.
- Good load, bytes back-to-back:
  - Stimulus: A5 02 01 20 82 E0 FD FF FF EA 54.
  - Required: mem_we pulse with addr 0 / data 0xE0822001, then addr 1 / data 0xEAFFFFFD.
  - Then done=1, cpu_nreset=1, error=0.
- Bad checksum: same frame with last byte 0x55 -> both writes still occur, then error=1, cpu_nreset=0, done=0.
- Length errors:
  - A5 00 -> error=1, no mem_we.
  - A5 09 (CODE_WORDS=8) -> error=1, no mem_we.
  - A following valid frame -> done=1.
- Garbage and throttling: 3C 77 before A5 are ignored. Random in_valid gaps inside DATA give identical writes to the good-load case. A data byte of A5 inside a word is stored, not treated as sync.
- Reload and reset mid-frame:
  - After done, send A5: cpu_nreset=0 the next cycle.
  - nreset=0 after 5 data bytes -> all outputs return to reset values.
  - A new full frame loads correctly.
